// File: rtl/latch_bank_write_arbiter.sv
// Round-robin write sequencer sharing one gated-latch bank between N_REQ clients.
// Define LATCH_RB_CHECK_EN to add Q readback checking (Q_rb input, sticky Err output).
module latch_bank_write_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned EN_CYCLES = 2,
    localparam int unsigned IDW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic [N_REQ-1:0]       Req,
    input  logic [N_REQ*WIDTH-1:0] Wdata,
    output logic [N_REQ-1:0]       Ack,
    output logic                   Busy,
    output logic [IDW-1:0]         Grant_id,
    output logic [WIDTH-1:0]       D,
    output logic                   E
`ifdef LATCH_RB_CHECK_EN
    ,
    input  logic [WIDTH-1:0]       Q_rb,
    output logic                   Err
`endif
);

    localparam int unsigned CW = (EN_CYCLES > 1) ? $clog2(EN_CYCLES) : 1;

    generate
        if (EN_CYCLES < 1) begin : gEnCyclesCheck
            $error("EN_CYCLES must be at least 1");
        end
        if (N_REQ < 2 || N_REQ > 16) begin : gNReqCheck
            $error("N_REQ must be in 2..16");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ENABLE,
        HOLD,
        DONE
    } state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [CW-1:0]  enCnt;
    logic [IDW-1:0] win;
    logic [IDW-1:0] cand;
    logic           anyReq;

    // First set request at or above the pointer, wrapping at N_REQ.
    always_comb begin
        anyReq = 1'b0;
        win    = '0;
        cand   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = IDW'((32'(ptr) + k) % N_REQ);
            if (!anyReq && Req[cand]) begin
                anyReq = 1'b1;
                win    = cand;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            enCnt    <= '0;
            Ack      <= '0;
            Busy     <= 1'b0;
            Grant_id <= '0;
            D        <= '0;
            E        <= 1'b0;
`ifdef LATCH_RB_CHECK_EN
            Err      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    Ack <= '0;
                    if (anyReq) begin
                        // D doubles as the holding register; it only changes here.
                        Grant_id <= win;
                        D        <= Wdata[win*WIDTH +: WIDTH];
                        ptr      <= (win == IDW'(N_REQ - 1)) ? '0 : win + 1'b1;
                        Busy     <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    E     <= 1'b1;
                    enCnt <= '0;
                    state <= ENABLE;
                end
                ENABLE: begin
                    if (enCnt == CW'(EN_CYCLES - 1)) begin
                        E     <= 1'b0;
                        state <= HOLD;
                    end else begin
                        enCnt <= enCnt + 1'b1;
                    end
                end
                HOLD: begin
                    Ack   <= N_REQ'(1) << Grant_id;
`ifdef LATCH_RB_CHECK_EN
                    if (Q_rb != D) begin
                        Err <= 1'b1;
                    end
`endif
                    state <= DONE;
                end
                DONE: begin
                    Ack   <= '0;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    Ack   <= '0;
                    Busy  <= 1'b0;
                    E     <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_latch_bank_write_arbiter.sv
// Directed bench for latch_bank_write_arbiter (N_REQ=4, WIDTH=8, EN_CYCLES=2).
module tb_latch_bank_write_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic         Clk = 1'b0;
    logic         Rst_n;
    logic [N-1:0] Req;
    logic [N*W-1:0] Wdata;
    logic [N-1:0] Ack;
    logic         Busy;
    logic [1:0]   Grant_id;
    logic [W-1:0] D;
    logic         E;
    logic [W-1:0] bankQ;
    logic         forceQ;
`ifdef LATCH_RB_CHECK_EN
    logic [W-1:0] qRb;
    logic         Err;
    assign qRb = forceQ ? '0 : bankQ;
`endif

    int nChecks = 0;
    int nPass   = 0;

    latch_bank_write_arbiter #(.N_REQ(N), .WIDTH(W), .EN_CYCLES(2)) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Req      (Req),
        .Wdata    (Wdata),
        .Ack      (Ack),
        .Busy     (Busy),
        .Grant_id (Grant_id),
        .D        (D),
        .E        (E)
`ifdef LATCH_RB_CHECK_EN
        ,
        .Q_rb     (qRb),
        .Err      (Err)
`endif
    );

    always #5 Clk = ~Clk;

    // Behavioural model of the latch bank being driven.
    always_latch begin
        if (E) bankQ <= D;
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    // Ticks until an Ack appears; cyc = ticks taken, or -1 after 30.
    task automatic waitAck(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 30 && cyc < 0; i++) begin
            tick();
            if (Ack != '0) cyc = i;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int cyc;
        int exp;
        Rst_n  = 1'b0;
        Req    = '0;
        Wdata  = '0;
        forceQ = 1'b0;
        #3;
        checkVal("rst_D", 32'(D), 0);
        checkVal("rst_E", 32'(E), 0);
        checkVal("rst_Ack", 32'(Ack), 0);
        checkVal("rst_Busy", 32'(Busy), 0);
        checkVal("rst_Gid", 32'(Grant_id), 0);
        tick();
        tick();
        Rst_n = 1'b1;

        // Single write from requester 0; this is cycle 0.
        Req         = 4'b0001;
        Wdata[7:0]  = 8'hA5;
        for (int c = 1; c <= 6; c++) begin
            tick();
            checkVal($sformatf("sw_E_c%0d", c), 32'(E), (c == 2 || c == 3) ? 1 : 0);
            checkVal($sformatf("sw_Busy_c%0d", c), 32'(Busy), (c <= 5) ? 1 : 0);
            checkVal($sformatf("sw_Ack_c%0d", c), 32'(Ack), (c == 5) ? 1 : 0);
            checkVal($sformatf("sw_D_c%0d", c), 32'(D), 32'hA5);
            if (c == 5) Req = '0;
        end

        // Contention from reset: grants 0,1,2,3,0 at 6-cycle spacing.
        Rst_n = 1'b0;
        Wdata = {8'h13, 8'h12, 8'h11, 8'h10};
        Req   = 4'b1111;
        tick();
        Rst_n = 1'b1;
        for (int g = 0; g < 5; g++) begin
            exp = g % 4;
            waitAck(cyc);
            checkVal($sformatf("rr_lat_%0d", g), 32'(cyc), (g == 0) ? 5 : 6);
            checkVal($sformatf("rr_Ack_%0d", g), 32'(Ack), 32'(1) << exp);
            checkVal($sformatf("rr_Gid_%0d", g), 32'(Grant_id), 32'(exp));
            checkVal($sformatf("rr_D_%0d", g), 32'(D), 32'h10 + 32'(exp));
        end
        Req = 4'b0100;
        waitAck(cyc);
        checkVal("wrap_pre_Gid", 32'(Grant_id), 2);

        // Pointer now 3: 1001 must serve 3 before 0.
        Req = 4'b1001;
        waitAck(cyc);
        checkVal("wrap_lat3", 32'(cyc), 6);
        checkVal("wrap_Ack3", 32'(Ack), 32'b1000);
        checkVal("wrap_Gid3", 32'(Grant_id), 3);
        Req = 4'b0001;
        waitAck(cyc);
        checkVal("wrap_lat0", 32'(cyc), 6);
        checkVal("wrap_Ack0", 32'(Ack), 32'b0001);
        checkVal("wrap_Gid0", 32'(Grant_id), 0);

        // Wdata change and Req drop during ENABLE.
        Req          = 4'b0010;
        Wdata[15:8]  = 8'h3C;
        tick();
        tick();
        tick();
        checkVal("ds_E_c2", 32'(E), 1);
        Wdata[15:8] = 8'hFF;
        Req         = '0;
        tick();
        checkVal("ds_E_c3", 32'(E), 1);
        checkVal("ds_D_c3", 32'(D), 32'h3C);
        tick();
        checkVal("ds_E_c4", 32'(E), 0);
        checkVal("ds_D_c4", 32'(D), 32'h3C);
        waitAck(cyc);
        checkVal("ds_lat", 32'(cyc), 1);
        checkVal("ds_Ack", 32'(Ack), 32'b0010);
        checkVal("ds_bankQ", 32'(bankQ), 32'h3C);

        // Asynchronous reset while E is high.
        Req = 4'b0100;
        tick();
        tick();
        tick();
        checkVal("ra_E_pre", 32'(E), 1);
        checkVal("ra_Gid_pre", 32'(Grant_id), 2);
        #2;
        Rst_n = 1'b0;
        Req   = 4'b0010;
        #1;
        checkVal("ra_E", 32'(E), 0);
        checkVal("ra_D", 32'(D), 0);
        checkVal("ra_Busy", 32'(Busy), 0);
        checkVal("ra_Gid", 32'(Grant_id), 0);
        checkVal("ra_Ack", 32'(Ack), 0);
        tick();
        checkVal("ra_Ack_held", 32'(Ack), 0);
        Rst_n = 1'b1;
        waitAck(cyc);
        checkVal("ra_lat", 32'(cyc), 5);
        checkVal("ra_Ack_after", 32'(Ack), 32'b0010);
        checkVal("ra_Gid_after", 32'(Grant_id), 1);
        checkVal("ra_D_after", 32'(D), 32'hFF);
        Req = '0;

`ifdef LATCH_RB_CHECK_EN
        checkVal("rb_Err_init", 32'(Err), 0);
        forceQ     = 1'b1;
        Req        = 4'b0001;
        Wdata[7:0] = 8'h5A;
        for (int c = 0; c <= 5; c++) begin
            tick();
            if (c == 4) checkVal("rb_Err_hold", 32'(Err), 0);
        end
        checkVal("rb_Ack", 32'(Ack), 32'b0001);
        checkVal("rb_Err_set", 32'(Err), 1);
        forceQ     = 1'b0;
        Wdata[7:0] = 8'h11;
        waitAck(cyc);
        checkVal("rb_good_Ack", 32'(Ack), 32'b0001);
        checkVal("rb_Err_sticky", 32'(Err), 1);
        Req = '0;
        #2;
        Rst_n = 1'b0;
        #1;
        checkVal("rb_Err_rst", 32'(Err), 0);
        tick();
        Rst_n = 1'b1;
`endif

        tick();
        checkVal("end_Ack", 32'(Ack), 0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
